// File: rtl/game_pkg.sv
// game_pkg: shared types and width helpers for the guess/turn scheduler.
//   state_e - scheduler FSM states
//   try_w   - bits needed to hold 0..max_tries
//   sel_w   - bits needed to index n players (minimum 1)
package game_pkg;

    typedef enum logic [2:0] {
        StGen,
        StTurn,
        StRelease,
        StCheck,
        StEnd
    } state_e;

    function automatic int unsigned try_w(input int unsigned max_tries);
        return $clog2(max_tries + 1);
    endfunction

    function automatic int unsigned sel_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_next_player.sv
// rr_next_player: combinational round-robin search for the next player holding tries.
//   tries - packed per-player try counts, player p at [p*TRY_W +: TRY_W]
//   cur   - current player; the search starts at cur+1 and wraps, cur itself is checked last
//   next  - first player in that order with non-zero tries
//   found - high when such a player exists
module rr_next_player #(
    parameter int unsigned N     = 2,
    parameter int unsigned TRY_W = 3,
    parameter int unsigned SEL_W = 1
) (
    input  logic [N*TRY_W-1:0] tries,
    input  logic [SEL_W-1:0]   cur,
    output logic [SEL_W-1:0]   next,
    output logic               found
);

    int unsigned idx;

    always_comb begin
        next  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(cur) + k) % N;
            if (!found && tries[idx*TRY_W +: TRY_W] != '0) begin
                found = 1'b1;
                next  = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/guess_turn_scheduler.sv
// guess_turn_scheduler: shares one guess/compare datapath between N_PLAYERS players.
// Freezes the free-running target on the first press, grants turns round-robin, tracks
// remaining tries, pulses the LED update after every checked guess and reports the result.
//   clk, reset     - clock, synchronous active-high reset
//   i_enter        - per-player enter buttons (level, synchronised)
//   i_equal        - datapath compare result for the selected guess
//   i_new_game     - restart request, honoured only once the game has ended
//   o_sel          - player currently owning the datapath
//   o_inc_actual   - target increment enable (only while generating)
//   o_update_leds  - one-cycle pulse when a guess is checked
//   o_tries        - packed remaining tries, player p at [p*TRY_W +: TRY_W]
//   o_done/o_win/o_winner - game over, someone guessed, who guessed
// Optional: define TURN_TIMEOUT_EN to forfeit a try after TIMEOUT_CYCLES idle turn cycles.
module guess_turn_scheduler import game_pkg::*; #(
    parameter  int unsigned N_PLAYERS      = 2,
    parameter  int unsigned MAX_TRIES      = 7,
    parameter  int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned TRY_W          = try_w(MAX_TRIES),
    localparam int unsigned SEL_W          = sel_w(N_PLAYERS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_PLAYERS-1:0]       i_enter,
    input  logic                       i_equal,
    input  logic                       i_new_game,
    output logic [SEL_W-1:0]           o_sel,
    output logic                       o_inc_actual,
    output logic                       o_update_leds,
    output logic [N_PLAYERS*TRY_W-1:0] o_tries,
    output logic                       o_done,
    output logic                       o_win,
    output logic [SEL_W-1:0]           o_winner
);

    localparam logic [TRY_W-1:0] TriesInit = TRY_W'(MAX_TRIES);

    if (N_PLAYERS < 1 || N_PLAYERS > 8 || MAX_TRIES < 1 || MAX_TRIES > 15 ||
        TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("guess_turn_scheduler: parameter out of range");
    end

    state_e                       state_q;
    logic [SEL_W-1:0]             cur_q;
    logic [TRY_W-1:0]             tries_q [N_PLAYERS];
    logic                         done_q;
    logic                         win_q;
    logic [SEL_W-1:0]             winner_q;

    logic [N_PLAYERS*TRY_W-1:0]   tries_post;
    logic [SEL_W-1:0]             next_sel;
    logic                         next_found;
    logic                         forfeit;

`ifdef TURN_TIMEOUT_EN
    localparam int unsigned       CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CntLast = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]             timeout_cnt_q;
    logic                         forfeit_q;
    assign forfeit = forfeit_q;
`else
    assign forfeit = 1'b0;
`endif

    // Tries as they will be after the current player's check (saturating at zero); the
    // round-robin search must see the post-decrement count of the current player.
    always_comb begin
        tries_post = '0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            if (p == int'(cur_q) && tries_q[p] != '0) begin
                tries_post[p*TRY_W +: TRY_W] = tries_q[p] - TRY_W'(1);
            end else begin
                tries_post[p*TRY_W +: TRY_W] = tries_q[p];
            end
        end
    end

    rr_next_player #(
        .N     (N_PLAYERS),
        .TRY_W (TRY_W),
        .SEL_W (SEL_W)
    ) u_rr_next_player (
        .tries (tries_post),
        .cur   (cur_q),
        .next  (next_sel),
        .found (next_found)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StGen;
            cur_q    <= '0;
            done_q   <= 1'b0;
            win_q    <= 1'b0;
            winner_q <= '0;
            for (int p = 0; p < N_PLAYERS; p++) tries_q[p] <= TriesInit;
`ifdef TURN_TIMEOUT_EN
            timeout_cnt_q <= '0;
            forfeit_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                StGen: begin
                    // Player 0's press both freezes the target and is their first guess.
                    if (i_enter[0]) begin
                        cur_q   <= '0;
                        state_q <= StRelease;
                    end
                end
                StTurn: begin
                    if (i_enter[cur_q]) begin
                        state_q <= StRelease;
                    end
`ifdef TURN_TIMEOUT_EN
                    else if (timeout_cnt_q == CntLast) begin
                        state_q   <= StCheck;
                        forfeit_q <= 1'b1;
                    end else begin
                        timeout_cnt_q <= timeout_cnt_q + CNT_W'(1);
                    end
`endif
                end
                StRelease: begin
                    if (!i_enter[cur_q]) state_q <= StCheck;
                end
                StCheck: begin
                    for (int p = 0; p < N_PLAYERS; p++) begin
                        tries_q[p] <= tries_post[p*TRY_W +: TRY_W];
                    end
`ifdef TURN_TIMEOUT_EN
                    forfeit_q     <= 1'b0;
                    timeout_cnt_q <= '0;
`endif
                    if (i_equal && !forfeit) begin
                        state_q  <= StEnd;
                        done_q   <= 1'b1;
                        win_q    <= 1'b1;
                        winner_q <= cur_q;
                    end else if (next_found) begin
                        cur_q   <= next_sel;
                        state_q <= StTurn;
                    end else begin
                        state_q <= StEnd;
                        done_q  <= 1'b1;
                        win_q   <= 1'b0;
                    end
                end
                StEnd: begin
                    if (i_new_game) begin
                        state_q  <= StGen;
                        cur_q    <= '0;
                        done_q   <= 1'b0;
                        win_q    <= 1'b0;
                        winner_q <= '0;
                        for (int p = 0; p < N_PLAYERS; p++) tries_q[p] <= TriesInit;
                    end
                end
                default: state_q <= StGen;
            endcase
        end
    end

    always_comb begin
        o_tries = '0;
        for (int p = 0; p < N_PLAYERS; p++) o_tries[p*TRY_W +: TRY_W] = tries_q[p];
    end

    assign o_sel         = cur_q;
    assign o_inc_actual  = (state_q == StGen);
    assign o_update_leds = (state_q == StCheck) && !forfeit;
    assign o_done        = done_q;
    assign o_win         = win_q;
    assign o_winner      = winner_q;

endmodule

// File: tb/tb_guess_turn_scheduler.sv
// Bench for guess_turn_scheduler: two players, seven tries each, directed scenarios plus
// randomized games checked against a simple game model.
module tb_guess_turn_scheduler;

    localparam int NP  = 2;
    localparam int MT  = 7;
    localparam int TW  = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP-1:0]   i_enter;
    logic            i_equal;
    logic            i_new_game;
    logic [0:0]      o_sel;
    logic            o_inc_actual;
    logic            o_update_leds;
    logic [NP*TW-1:0] o_tries;
    logic            o_done;
    logic            o_win;
    logic [0:0]      o_winner;

    int n_tests = 0;
    int n_fail  = 0;

    // Game model
    int m_tries [NP];
    int m_cur;
    bit m_done;
    bit m_win;
    int m_winner;

    guess_turn_scheduler #(
        .N_PLAYERS      (NP),
        .MAX_TRIES      (MT),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_enter       (i_enter),
        .i_equal       (i_equal),
        .i_new_game    (i_new_game),
        .o_sel         (o_sel),
        .o_inc_actual  (o_inc_actual),
        .o_update_leds (o_update_leds),
        .o_tries       (o_tries),
        .o_done        (o_done),
        .o_win         (o_win),
        .o_winner      (o_winner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int p = 0; p < NP; p++) m_tries[p] = MT;
        m_cur    = 0;
        m_done   = 0;
        m_win    = 0;
        m_winner = 0;
    endfunction

    function automatic void model_check(input bit eq, input bit forfeit);
        int nxt;
        bit found;
        if (m_tries[m_cur] > 0) m_tries[m_cur] = m_tries[m_cur] - 1;
        if (eq && !forfeit) begin
            m_done = 1; m_win = 1; m_winner = m_cur;
        end else begin
            found = 0;
            nxt   = 0;
            for (int k = 1; k <= NP; k++) begin
                if (!found && m_tries[(m_cur + k) % NP] > 0) begin
                    found = 1;
                    nxt   = (m_cur + k) % NP;
                end
            end
            if (found) m_cur = nxt;
            else begin
                m_done = 1; m_win = 0;
            end
        end
    endfunction

    function automatic logic [NP*TW-1:0] model_tries();
        logic [NP*TW-1:0] v;
        v = '0;
        for (int p = 0; p < NP; p++) v[p*TW +: TW] = TW'(m_tries[p]);
        return v;
    endfunction

    function automatic int dut_tries(input int p);
        return int'(o_tries[p*TW +: TW]);
    endfunction

    // Drives one complete guess by player p (idle, press, hold, release, check) and counts
    // how many sampled cycles had the LED update high.
    task automatic play_guess(input int p, input bit eq, input int pre, input int hold,
                              input bit noise, output int pulses);
        pulses = 0;
        repeat (pre) begin
            i_enter = '0;
            if (noise) i_enter[1-p] = 1'($urandom_range(0, 1));
            tick();
            pulses += int'(o_update_leds);
        end
        i_enter    = '0;
        i_enter[p] = 1'b1;
        tick();
        pulses += int'(o_update_leds);
        repeat (hold) begin
            if (noise) i_enter[1-p] = 1'($urandom_range(0, 1));
            tick();
            pulses += int'(o_update_leds);
        end
        i_enter = '0;
        if (noise) i_enter[1-p] = 1'($urandom_range(0, 1));
        tick();
        pulses += int'(o_update_leds);
        i_equal = eq;
        tick();
        pulses += int'(o_update_leds);
        i_equal = 1'b0;
        i_enter = '0;
    endtask

    task automatic test_reset();
        int inc_cycles;
        reset = 1'b1; i_enter = '0; i_equal = 1'b0; i_new_game = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        n_tests++; if (o_inc_actual !== 1'b1) begin n_fail++; $display("FAIL reset_inc: got %b expected 1", o_inc_actual); end
        n_tests++; if (o_sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %0d expected 0", o_sel); end
        n_tests++; if (o_tries !== 6'b111111) begin n_fail++; $display("FAIL reset_tries: got %b expected 111111", o_tries); end
        n_tests++; if ({o_done, o_win, o_winner} !== 3'b000) begin n_fail++; $display("FAIL reset_result: got %b expected 000", {o_done, o_win, o_winner}); end
        inc_cycles = 0;
        for (int c = 0; c < 37; c++) begin
            if (NP > 1) i_enter[1] = 1'($urandom_range(0, 1));
            tick();
            if (o_inc_actual === 1'b1 && o_sel === 1'b0 && o_update_leds === 1'b0) inc_cycles++;
        end
        i_enter = '0;
        n_tests++; if (inc_cycles != 37) begin n_fail++; $display("FAIL gen_hold: got %0d gen cycles expected 37", inc_cycles); end
        n_tests++; if (o_tries !== 6'b111111) begin n_fail++; $display("FAIL gen_tries: got %b expected 111111", o_tries); end
    endtask

    task automatic test_first_turn();
        int pulses;
        play_guess(0, 1'b0, 0, 2, 1'b0, pulses);
        model_check(1'b0, 1'b0);
        n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL first_pulse: got %0d expected 1", pulses); end
        n_tests++; if (dut_tries(0) != 6) begin n_fail++; $display("FAIL first_tries0: got %0d expected 6", dut_tries(0)); end
        n_tests++; if (o_sel !== 1'b1) begin n_fail++; $display("FAIL first_sel: got %0d expected 1", o_sel); end
        n_tests++; if (o_inc_actual !== 1'b0 || o_done !== 1'b0) begin n_fail++; $display("FAIL first_state: got inc=%b done=%b expected 0 0", o_inc_actual, o_done); end
    endtask

    task automatic test_ignore_other();
        int pulses;
        pulses = 0;
        // p0 presses during p1's turn; the new-game request is also ignored outside the end state.
        i_enter = 2'b01;
        i_new_game = 1'b1;
        repeat (3) begin tick(); pulses += int'(o_update_leds); end
        i_enter = '0;
        i_new_game = 1'b0;
        repeat (2) begin tick(); pulses += int'(o_update_leds); end
        n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL ignore_pulse: got %0d expected 0", pulses); end
        n_tests++; if (o_sel !== 1'b1) begin n_fail++; $display("FAIL ignore_sel: got %0d expected 1", o_sel); end
        n_tests++; if (o_tries !== model_tries()) begin n_fail++; $display("FAIL ignore_tries: got %b expected %b", o_tries, model_tries()); end
        play_guess(1, 1'b1, 1, 1, 1'b0, pulses);
        model_check(1'b1, 1'b0);
        n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL win_pulse: got %0d expected 1", pulses); end
        n_tests++; if ({o_done, o_win} !== 2'b11) begin n_fail++; $display("FAIL win_flags: got %b expected 11", {o_done, o_win}); end
        n_tests++; if (o_winner !== 1'b1) begin n_fail++; $display("FAIL win_winner: got %0d expected 1", o_winner); end
        n_tests++; if (o_tries !== model_tries()) begin n_fail++; $display("FAIL win_tries: got %b expected %b", o_tries, model_tries()); end
    endtask

    task automatic test_new_game();
        int held;
        held = 0;
        for (int c = 0; c < 4; c++) begin
            i_enter = NP'($urandom_range(0, 3));
            i_equal = 1'($urandom_range(0, 1));
            tick();
            if (o_done === 1'b1 && o_win === 1'b1 && o_winner === 1'b1 && o_update_leds === 1'b0) held++;
        end
        i_enter = '0; i_equal = 1'b0;
        n_tests++; if (held != 4) begin n_fail++; $display("FAIL end_hold: got %0d held cycles expected 4", held); end
        i_new_game = 1'b1;
        tick();
        i_new_game = 1'b0;
        model_reset();
        n_tests++; if (o_inc_actual !== 1'b1) begin n_fail++; $display("FAIL newgame_inc: got %b expected 1", o_inc_actual); end
        n_tests++; if (o_tries !== 6'b111111) begin n_fail++; $display("FAIL newgame_tries: got %b expected 111111", o_tries); end
        n_tests++; if ({o_done, o_win, o_winner, o_sel} !== 4'b0000) begin n_fail++; $display("FAIL newgame_result: got %b expected 0000", {o_done, o_win, o_winner, o_sel}); end
    endtask

    task automatic test_exhaust();
        int pulses;
        int bad_pulse;
        bad_pulse = 0;
        for (int k = 0; k < 2 * MT; k++) begin
            n_tests++; if (o_sel !== 1'(k % 2)) begin n_fail++; $display("FAIL exhaust_order[%0d]: got %0d expected %0d", k, o_sel, k % 2); end
            play_guess(k % 2, 1'b0, 1, 0, 1'b0, pulses);
            model_check(1'b0, 1'b0);
            if (pulses != 1) bad_pulse++;
        end
        n_tests++; if (bad_pulse != 0) begin n_fail++; $display("FAIL exhaust_pulses: got %0d bad checks expected 0", bad_pulse); end
        n_tests++; if ({o_done, o_win} !== 2'b10) begin n_fail++; $display("FAIL exhaust_flags: got %b expected 10", {o_done, o_win}); end
        n_tests++; if (o_tries !== '0) begin n_fail++; $display("FAIL exhaust_tries: got %b expected 0", o_tries); end
        i_new_game = 1'b1;
        tick();
        i_new_game = 1'b0;
        model_reset();
    endtask

    task automatic test_reset_mid();
        int pulses;
        play_guess(0, 1'b0, 0, 0, 1'b0, pulses);
        i_enter = 2'b10;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        i_enter = '0;
        model_reset();
        n_tests++; if (o_inc_actual !== 1'b1) begin n_fail++; $display("FAIL midreset_inc: got %b expected 1", o_inc_actual); end
        n_tests++; if (o_tries !== 6'b111111) begin n_fail++; $display("FAIL midreset_tries: got %b expected 111111", o_tries); end
        n_tests++; if (o_sel !== 1'b0 || o_update_leds !== 1'b0) begin n_fail++; $display("FAIL midreset_sel: got sel=%0d upd=%b expected 0 0", o_sel, o_update_leds); end
        tick();
        n_tests++; if (o_inc_actual !== 1'b1) begin n_fail++; $display("FAIL midreset_stay: got %b expected 1", o_inc_actual); end
    endtask

    task automatic test_random_games();
        int pulses;
        int guesses;
        bit eq;
        for (int g = 0; g < 8; g++) begin
            guesses = 0;
            while (!m_done && guesses < 2 * MT + 2) begin
                eq = ($urandom_range(0, 9) == 0);
                play_guess(m_cur, eq, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, pulses);
                model_check(eq, 1'b0);
                guesses++;
                n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL rand_pulse g%0d: got %0d expected 1", g, pulses); end
                n_tests++; if (o_tries !== model_tries()) begin n_fail++; $display("FAIL rand_tries g%0d: got %b expected %b", g, o_tries, model_tries()); end
                n_tests++; if (o_done !== m_done) begin n_fail++; $display("FAIL rand_done g%0d: got %b expected %b", g, o_done, m_done); end
                if (!m_done) begin
                    n_tests++; if (int'(o_sel) != m_cur) begin n_fail++; $display("FAIL rand_sel g%0d: got %0d expected %0d", g, o_sel, m_cur); end
                end else begin
                    n_tests++; if (o_win !== m_win) begin n_fail++; $display("FAIL rand_win g%0d: got %b expected %b", g, o_win, m_win); end
                    if (m_win) begin
                        n_tests++; if (int'(o_winner) != m_winner) begin n_fail++; $display("FAIL rand_winner g%0d: got %0d expected %0d", g, o_winner, m_winner); end
                    end
                end
            end
            n_tests++; if (!m_done) begin n_fail++; $display("FAIL rand_bound g%0d: game did not end within %0d guesses", g, guesses); end
            i_new_game = 1'b1;
            tick();
            i_new_game = 1'b0;
            model_reset();
        end
    endtask

`ifdef TURN_TIMEOUT_EN
    task automatic test_timeout();
        int pulses;
        play_guess(0, 1'b0, 0, 0, 1'b0, pulses);
        model_check(1'b0, 1'b0);
        pulses = 0;
        repeat (15) begin tick(); pulses += int'(o_update_leds); end
        n_tests++; if (o_sel !== 1'b1) begin n_fail++; $display("FAIL timeout_early: got sel %0d expected 1", o_sel); end
        tick(); pulses += int'(o_update_leds);
        tick(); pulses += int'(o_update_leds);
        model_check(1'b0, 1'b1);
        n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL timeout_pulse: got %0d expected 0", pulses); end
        n_tests++; if (o_sel !== 1'b0) begin n_fail++; $display("FAIL timeout_sel: got %0d expected 0", o_sel); end
        n_tests++; if (o_tries !== model_tries()) begin n_fail++; $display("FAIL timeout_tries: got %b expected %b", o_tries, model_tries()); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_first_turn();
        test_ignore_other();
        test_new_game();
        test_exhaust();
        test_reset_mid();
        test_random_games();
`ifdef TURN_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
